// File: rtl/ntsc_pixel_packer.sv
// ntsc_pixel_packer: packs a video pixel stream into ZBT words and queues them for the write arbiter
module ntsc_pixel_packer #(
  parameter int PIX_W        = 18,
  parameter int PIX_PER_WORD = 2,
  parameter int WORD_W       = 36,
  parameter int ADDR_W       = 19,
  parameter int Y_BITS       = 9,
  parameter int COL_START    = 30,
  parameter int ROW_START    = 30,
  parameter int MAX_COL      = 1024,
  parameter int MAX_ROW      = 768,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_valid,
  input  logic [PIX_W-1:0]  pix_data,
  input  logic              line_start,
  input  logic              field_start,
  input  logic              field,
  input  logic              capture_en,
  input  logic              mode,
  input  logic              ovf_clr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_data,
  input  logic              mem_ack,
  output logic              overflow,
  output logic              field_done
);
  localparam int CW = $clog2(MAX_COL + 1);
  localparam int RW = $clog2(MAX_ROW + 1);
  localparam int XB = ADDR_W - Y_BITS - 1;
  localparam int PW = PIX_W * PIX_PER_WORD;
  localparam int FW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, ACTIVE, FROZEN} state_t;
  state_t            r_state, w_state;
  logic [RW-1:0]     r_row, w_row;
  logic [CW-1:0]     r_col, w_col, w_lane, w_c0;
  logic              r_eo, r_mode, w_eo, w_mode, w_line, w_pix, w_cap, w_top;
  logic              w_done, w_flush, w_hold, w_pop, w_wr;
  logic [PW-1:0]     r_buf, w_new;
  logic [ADDR_W-1:0] r_addr, w_addr, r_paddr;
  logic [WORD_W-1:0] r_pdata;
  logic              r_any, r_push, r_ovf, r_fd;
  logic [ADDR_W-1:0] r_fa [FIFO_DEPTH];
  logic [WORD_W-1:0] r_fdat [FIFO_DEPTH];
  logic [FW-1:0]     r_wp, r_rp;
  logic [FW:0]       r_cnt;
  always_comb begin
    w_line  = line_start && r_state != IDLE;
    w_state = field_start ? (capture_en ? ACTIVE : FROZEN) : r_state;
    w_row   = field_start ? RW'(ROW_START) : (w_line && r_row != RW'(MAX_ROW)) ? r_row + 1'b1 : r_row;
    w_col   = (field_start || w_line) ? CW'(COL_START) : r_col;
    w_eo    = field_start ? field : r_eo;
    w_mode  = field_start ? mode : r_mode;
    w_pix   = pix_valid && w_state != IDLE && w_col < CW'(MAX_COL) && w_row < RW'(MAX_ROW);
    w_cap   = w_pix && w_state == ACTIVE;
    w_lane  = w_col % CW'(PIX_PER_WORD);
    w_top   = w_mode || w_lane == CW'(PIX_PER_WORD - 1);
    w_c0    = w_mode ? w_col : w_col / CW'(PIX_PER_WORD);
    w_addr  = {Y_BITS'(w_row), w_eo, XB'(w_c0)};
    // a pending word always leaves first; a pixel colliding with that flush is parked in the buffer
    w_flush = r_any && (field_start || w_line || (w_cap && w_mode));
    w_done  = w_cap && w_top && !w_flush;
    w_hold  = w_cap && (!w_top || w_flush);
    w_new   = (field_start || w_line) ? '0 : r_buf;
    for (int l = 0; l < PIX_PER_WORD; l++)
      if (w_mode || w_lane == CW'(l)) w_new[(PIX_PER_WORD-1-l)*PIX_W +: PIX_W] = pix_data;
    w_pop   = mem_req && mem_ack;
    w_wr    = r_push && (r_cnt != (FW+1)'(FIFO_DEPTH) || w_pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_row   <= '0;
      r_col   <= '0;
      r_eo    <= 1'b0;
      r_mode  <= 1'b0;
      r_buf   <= '0;
      r_any   <= 1'b0;
      r_addr  <= '0;
      r_push  <= 1'b0;
      r_paddr <= '0;
      r_pdata <= '0;
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
      r_fd    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_row   <= w_row;
      r_col   <= (pix_valid && w_state != IDLE && w_col != CW'(MAX_COL)) ? w_col + 1'b1 : w_col;
      r_eo    <= w_eo;
      r_mode  <= w_mode;
      r_fd    <= field_start && r_state == ACTIVE;
      r_push  <= w_flush || w_done;
      r_paddr <= w_flush ? r_addr : w_addr;
      r_pdata <= WORD_W'(w_flush ? r_buf : w_new);
      if (w_hold) begin
        r_buf  <= w_new;
        r_addr <= w_addr;
        r_any  <= 1'b1;
      end else if (w_flush || w_done) begin
        r_buf  <= '0;
        r_any  <= 1'b0;
      end
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt   <= r_cnt + {{FW{1'b0}}, w_wr} - {{FW{1'b0}}, w_pop};
      r_ovf   <= (r_push && !w_wr) || (r_ovf && !ovf_clr);
    end
  end
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_fa[r_wp]   <= r_paddr;
      r_fdat[r_wp] <= r_pdata;
    end
  end
  assign mem_req    = |r_cnt;
  assign mem_addr   = r_fa[r_rp];
  assign mem_data   = r_fdat[r_rp];
  assign overflow   = r_ovf;
  assign field_done = r_fd;
endmodule
